// File: rtl/phoenix_rom_pkg.sv
// Shared types and address-map constants for the Phoenix ROM download path.
package phoenix_rom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        HOLD,
        RUN,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        RGN_PROG,
        RGN_BG,
        RGN_FG,
        RGN_PAL
    } region_t;

    // Region bases; each region ends where the next begins, the map ends at MAP_LIMIT.
    localparam logic [15:0] BG_BASE   = 16'h4000;
    localparam logic [15:0] FG_BASE   = 16'h5000;
    localparam logic [15:0] PAL_BASE  = 16'h6000;
    localparam logic [15:0] MAP_LIMIT = 16'h6200;

    localparam int unsigned EXPECTED_BYTES_DEFAULT = 25088;

endpackage

// File: rtl/phoenix_rom_region_decode.sv
// Combinational decode of a download byte address into target region and relative address.
module phoenix_rom_region_decode
    import phoenix_rom_pkg::*;
(
    input  logic [15:0] addr,
    output logic        in_map,
    output logic [2:0]  sel,
    output logic        pal,
    output logic [13:0] rel_addr
);

    region_t region;

    always_comb begin
        in_map = 1'b1;
        region = RGN_PROG;
        if (addr < BG_BASE)        region = RGN_PROG;
        else if (addr < FG_BASE)   region = RGN_BG;
        else if (addr < PAL_BASE)  region = RGN_FG;
        else if (addr < MAP_LIMIT) region = RGN_PAL;
        else                       in_map = 1'b0;

        sel      = '0;
        pal      = 1'b0;
        rel_addr = '0;
        case (region)
            RGN_PROG: begin
                sel      = 3'b001;
                rel_addr = addr[13:0];
            end
            RGN_BG: begin
                sel      = 3'b010;
                rel_addr = {2'b00, addr[11:0]};
            end
            RGN_FG: begin
                sel      = 3'b100;
                rel_addr = {2'b00, addr[11:0]};
            end
            default: begin
                sel      = 3'b100;
                pal      = 1'b1;
                rel_addr = {5'b00000, addr[8:0]};
            end
        endcase
    end

endmodule

// File: rtl/phoenix_rom_loader.sv
// Sequences the hps_io ROM download into Phoenix ROM/PROM ports, validates the image
// and owns the core reset.
module phoenix_rom_loader
    import phoenix_rom_pkg::*;
#(
    parameter int unsigned EXPECTED_BYTES = EXPECTED_BYTES_DEFAULT,
    parameter int unsigned RESET_HOLD     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        mem_wr_ready,
    output logic        mem_wr,
    output logic [2:0]  mem_sel,
    output logic        mem_pal,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err,
    output logic [16:0] byte_count
);

    state_t      state, state_nx;
    logic        in_map, dec_pal;
    logic [2:0]  dec_sel;
    logic [13:0] dec_addr;
    logic [7:0]  hold_cnt;
    logic        accept, done, drained, image_ok, enter_load, enter_err;

    phoenix_rom_region_decode u_decode (
        .addr     (dn_addr),
        .in_map   (in_map),
        .sel      (dec_sel),
        .pal      (dec_pal),
        .rel_addr (dec_addr)
    );

    assign accept     = dn_download & dn_wr & in_map & (state == LOAD);
    assign done       = mem_wr & mem_wr_ready;
    assign drained    = ~mem_wr | done;
    assign image_ok   = (byte_count == 17'(EXPECTED_BYTES)) & ~load_err;
    assign enter_load = (state_nx == LOAD) & (state != LOAD);
    assign enter_err  = (state_nx == ERR) & (state != ERR);

    always_comb begin
        state_nx   = state;
        core_reset = 1'b1;
        load_ok    = 1'b0;
        case (state)
            IDLE:  if (dn_download) state_nx = LOAD;
            // A buffer already empty at download end skips DRAIN so the hold
            // period starts on the edge the last byte leaves.
            LOAD: begin
                if (!dn_download) begin
                    if (!drained)      state_nx = DRAIN;
                    else if (image_ok) state_nx = HOLD;
                    else               state_nx = ERR;
                end
            end
            DRAIN: begin
                if (dn_download)   state_nx = LOAD;
                else if (drained)  state_nx = image_ok ? HOLD : ERR;
            end
            HOLD: begin
                if (dn_download)                          state_nx = LOAD;
                else if (hold_cnt == 8'(RESET_HOLD - 1))  state_nx = RUN;
            end
            RUN: begin
                core_reset = 1'b0;
                load_ok    = 1'b1;
                if (dn_download) state_nx = LOAD;
            end
            ERR:     if (dn_download) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_wr     <= 1'b0;
            mem_sel    <= '0;
            mem_pal    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            load_err   <= 1'b0;
            byte_count <= '0;
            hold_cnt   <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : '0;
            if (enter_load) begin
                byte_count <= '0;
                load_err   <= 1'b0;
                mem_wr     <= 1'b0;
            end else begin
                if (accept && drained) begin
                    mem_wr   <= 1'b1;
                    mem_sel  <= dec_sel;
                    mem_pal  <= dec_pal;
                    mem_addr <= dec_addr;
                    mem_data <= dn_data;
                    if (byte_count != '1) byte_count <= byte_count + 17'd1;
                end else begin
                    if (accept)    load_err <= 1'b1;
                    else if (done) mem_wr   <= 1'b0;
                end
                if (enter_err) load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phoenix_rom_loader.sv
// Scoreboard bench for phoenix_rom_loader: a reduced 64-byte image touching both
// ends of every region, with backpressure, out-of-map, reload and reset scenarios.
module tb_phoenix_rom_loader;

    localparam int unsigned IMG   = 64;
    localparam int unsigned RHOLD = 16;

    typedef struct packed {
        logic [2:0]  sel;
        logic        pal;
        logic [13:0] addr;
        logic [7:0]  data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dn_download = 1'b0;
    logic        dn_wr = 1'b0;
    logic [15:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        mem_wr_ready = 1'b1;
    logic        mem_wr, mem_pal, core_reset, load_ok, load_err;
    logic [2:0]  mem_sel;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data;
    logic [16:0] byte_count;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_xfer = 0;
    xfer_t sb_q[$];

    phoenix_rom_loader #(.EXPECTED_BYTES(IMG), .RESET_HOLD(RHOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .dn_download  (dn_download),
        .dn_wr        (dn_wr),
        .dn_addr      (dn_addr),
        .dn_data      (dn_data),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr       (mem_wr),
        .mem_sel      (mem_sel),
        .mem_pal      (mem_pal),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .core_reset   (core_reset),
        .load_ok      (load_ok),
        .load_err     (load_err),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Image byte i: region i/16, first 8 or last 8 offsets of that region.
    function automatic logic [15:0] img_off(input int unsigned i);
        logic [15:0] size;
        int unsigned k;
        k = i % 16;
        case (i / 16)
            0:       size = 16'h4000;
            1:       size = 16'h1000;
            2:       size = 16'h1000;
            default: size = 16'h0200;
        endcase
        return (k < 8) ? 16'(k) : 16'(32'(size) - 16 + k);
    endfunction

    function automatic logic [15:0] img_addr(input int unsigned i);
        logic [15:0] base;
        case (i / 16)
            0:       base = 16'h0000;
            1:       base = 16'h4000;
            2:       base = 16'h5000;
            default: base = 16'h6000;
        endcase
        return base + img_off(i);
    endfunction

    function automatic logic [7:0] img_data(input int unsigned i);
        return 8'(i * 29 + 11);
    endfunction

    function automatic xfer_t img_exp(input int unsigned i);
        xfer_t x;
        x.sel  = (i / 16 == 0) ? 3'b001 : (i / 16 == 1) ? 3'b010 : 3'b100;
        x.pal  = (i / 16 == 3);
        x.addr = 14'(img_off(i));
        x.data = img_data(i);
        return x;
    endfunction

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit expect_xfer,
                      input xfer_t x, input int unsigned gap);
        if (expect_xfer) sb_q.push_back(x);
        dn_addr = a;
        dn_data = d;
        dn_wr   = 1'b1;
        step(1);
        dn_wr   = 1'b0;
        if (gap > 0) step(gap);
    endtask

    task automatic send_img(input int unsigned first, input int unsigned last, input bit oom,
                            input int unsigned last_gap);
        for (int unsigned i = first; i <= last; i++) begin
            wr(img_addr(i), img_data(i), 1'b1, img_exp(i), (i == last && !oom) ? last_gap : 3);
            if (oom) wr(16'h6200 + 16'(i * 113) + ((i == 63) ? 16'h0260 : 16'h0), 8'hEE, 1'b0, '0,
                        (i == last) ? last_gap : 3);
        end
    endtask

    task automatic wait_run(input string name);
        int unsigned n = 0;
        while (!load_ok && n < 100) begin
            step(1);
            n++;
        end
        chk(name, 32'(load_ok), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, "_load_ok"},    32'(load_ok),    32'd0);
        chk({tag, "_load_err"},   32'(load_err),   32'd0);
        chk({tag, "_byte_count"}, 32'(byte_count), 32'd0);
        chk({tag, "_mem_wr"},     32'(mem_wr),     32'd0);
        chk({tag, "_mem_bus"},    32'({mem_sel, mem_pal, mem_addr, mem_data}), 32'd0);
    endtask

    // Monitor: pops on each completed transfer, checks held contents while stalled.
    always @(negedge clk) begin
        if (!reset && mem_wr) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_mem_wr", 32'({mem_sel, mem_pal, mem_addr, mem_data}), 32'hFFFFFFFF);
            end else if (mem_wr_ready) begin
                chk("xfer", 32'({mem_sel, mem_pal, mem_addr, mem_data}), 32'(sb_q[0]));
                void'(sb_q.pop_front());
                n_xfer++;
            end else begin
                chk("held_stable", 32'({mem_sel, mem_pal, mem_addr, mem_data}), 32'(sb_q[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int unsigned cnt;
        step(2);
        chk_reset_vals("por");
        reset = 1'b0;
        step(1);
        chk_reset_vals("idle");

        // Full valid image; core_reset falls RHOLD edges after the last transfer.
        dn_download = 1'b1;
        step(1);
        send_img(0, IMG - 1, 1'b0, 0);
        dn_download = 1'b0;
        step(1);
        chk("full_mem_wr_low", 32'(mem_wr), 32'd0);
        chk("full_hold_reset", 32'(core_reset), 32'd1);
        cnt = 0;
        while (core_reset && cnt < 100) begin
            step(1);
            cnt++;
        end
        chk("full_hold_cycles", cnt, RHOLD);
        chk("full_load_ok", 32'(load_ok), 32'd1);
        chk("full_load_err", 32'(load_err), 32'd0);
        chk("full_byte_count", 32'(byte_count), IMG);
        chk("full_xfers", n_xfer, IMG);

        // Reload from RUN with a second valid image.
        dn_download = 1'b1;
        step(1);
        chk("reload_core_reset", 32'(core_reset), 32'd1);
        chk("reload_load_ok", 32'(load_ok), 32'd0);
        chk("reload_byte_count", 32'(byte_count), 32'd0);
        send_img(0, IMG - 1, 1'b0, 3);
        dn_download = 1'b0;
        wait_run("reload_run");

        // Short image: one byte missing.
        dn_download = 1'b1;
        step(1);
        send_img(0, IMG - 2, 1'b0, 3);
        dn_download = 1'b0;
        step(2);
        chk("short_load_err", 32'(load_err), 32'd1);
        chk("short_byte_count", 32'(byte_count), IMG - 1);
        step(20);
        chk("short_core_reset", 32'(core_reset), 32'd1);
        chk("short_load_ok", 32'(load_ok), 32'd0);

        // Backpressure: second write while stalled is dropped.
        dn_download = 1'b1;
        step(1);
        chk("bp_err_cleared", 32'(load_err), 32'd0);
        mem_wr_ready = 1'b0;
        step(3);
        wr(16'h0123, 8'hA5, 1'b1, xfer_t'({3'b001, 1'b0, 14'h0123, 8'hA5}), 0);
        wr(16'h4456, 8'h5A, 1'b0, '0, 2);
        chk("bp_drop_err", 32'(load_err), 32'd1);
        chk("bp_drop_count", 32'(byte_count), 32'd1);
        chk("bp_still_full", 32'(mem_wr), 32'd1);
        mem_wr_ready = 1'b1;
        step(1);
        mem_wr_ready = 1'b0;
        wr(16'h5ABC, 8'h3C, 1'b1, xfer_t'({3'b100, 1'b0, 14'h0ABC, 8'h3C}), 0);
        mem_wr_ready = 1'b1;
        wr(16'h6155, 8'h99, 1'b1, xfer_t'({3'b100, 1'b1, 14'h0155, 8'h99}), 0);
        chk("bp_no_bubble", 32'(mem_wr), 32'd1);
        step(1);
        chk("bp_count", 32'(byte_count), 32'd3);
        dn_download = 1'b0;
        step(2);
        chk("bp_end_err", 32'(load_err), 32'd1);
        chk("bp_end_core_reset", 32'(core_reset), 32'd1);

        // Out-of-map bytes interleaved with a valid image.
        dn_download = 1'b1;
        step(1);
        send_img(0, IMG - 1, 1'b1, 3);
        chk("oom_byte_count", 32'(byte_count), IMG);
        dn_download = 1'b0;
        wait_run("oom_run");
        chk("oom_load_err", 32'(load_err), 32'd0);

        // Reset pulse mid-download with dn_download held.
        dn_download = 1'b1;
        step(1);
        send_img(0, 19, 1'b0, 3);
        reset = 1'b1;
        step(1);
        chk_reset_vals("midrst");
        reset = 1'b0;
        step(1);
        send_img(20, IMG - 1, 1'b0, 3);
        dn_download = 1'b0;
        step(2);
        chk("midrst_byte_count", 32'(byte_count), IMG - 20);
        chk("midrst_load_err", 32'(load_err), 32'd1);
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("queue_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phoenix_rom_loader.md
Name: phoenix_rom_loader

Overview:
- Sequences the HPS ROM download stream (ioctl) into the Phoenix core's ROM/PROM write ports.
- Decodes the download address into a target region and buffers one byte against target backpressure.
- Counts and validates the image, and owns the core reset: held through loading, released only after a valid image plus a settle delay.
- Sits between hps_io and the phoenix core in the emu top level, on clk_sys.

Parameters:
- EXPECTED_BYTES, 25088 (0x6200): exact in-map byte count for a valid image.
- RESET_HOLD, 16: cycles core_reset stays high after a valid load completes; legal range 1..255.

Ports:
- clk  in  1  system clock (clk_sys domain)
- reset  in  1  synchronous active-high reset
- dn_download  in  1  download active level
- dn_wr  in  1  one-cycle write strobe from hps_io
- dn_addr  in  16  download byte address
- dn_data  in  8  download byte
- mem_wr_ready  in  1  target ROM port accepts a write this cycle
- mem_wr  out  1  write request; held until accepted
- mem_sel  out  3  region one-hot: [0] program, [1] bg char, [2] fg char/palette group (see map)
- mem_pal  out  1  qualifies mem_sel[2]: 1 = palette PROM, 0 = fg char
- mem_addr  out  14  region-relative address
- mem_data  out  8  byte to write
- core_reset  out  1  reset to phoenix core
- load_ok  out  1  valid image loaded, core running
- load_err  out  1  sticky error for the last download
- byte_count  out  17  in-map writes accepted this download; saturates at 0x1FFFF

Behaviour:
- Address map:
  - 0x0000-0x3FFF: program; mem_addr = a[13:0].
  - 0x4000-0x4FFF: bg char; mem_addr = a[11:0].
  - 0x5000-0x5FFF: fg char; mem_addr = a[11:0], mem_pal = 0.
  - 0x6000-0x61FF: palette; mem_addr = a[8:0], mem_pal = 1.
  - Address >= 0x6200: out of map. Silently dropped, not counted, not an error.
- Reset values: state IDLE, core_reset = 1, load_ok = 0, load_err = 0, byte_count = 0, mem_wr = 0, buffer empty; mem_sel/mem_pal/mem_addr/mem_data = 0.
- Write acceptance:
  - A write is accepted only when dn_download = 1, dn_wr = 1, the address is in map and the state is LOAD.
  - An accepted write is registered into a 1-entry buffer. mem_wr rises the next cycle (latency 1). Outputs stay stable while mem_wr = 1.
  - A transfer completes on the cycle mem_wr & mem_wr_ready; the buffer empties at that edge.
  - If a transfer completes in the same cycle as a new accepted write, the new byte loads into the buffer (no bubble) and mem_wr stays high.
  - If an accepted write arrives while the buffer is full and no transfer completes that cycle: the byte is dropped, load_err is set, and byte_count is not incremented.
  - byte_count increments on every accepted in-map write that enters the buffer. Repeated addresses count again.
- States:
  - IDLE: core_reset = 1. Goes to LOAD when dn_download = 1.
  - LOAD: core_reset = 1, load_ok = 0. On entry, clear byte_count and load_err. Goes to DRAIN when dn_download = 0.
  - DRAIN: no new writes accepted. Waits for the buffer to empty. Then goes to HOLD if byte_count == EXPECTED_BYTES and load_err = 0; otherwise sets load_err and goes to ERR.
  - HOLD: core_reset = 1. Counts RESET_HOLD cycles, then goes to RUN.
  - RUN: core_reset = 0, load_ok = 1.
  - ERR: core_reset = 1, load_ok = 0.
  - Any of DRAIN, HOLD, RUN or ERR goes to LOAD on dn_download = 1; a restart during DRAIN discards the buffered byte.
- Reset mid-download returns everything to reset values and forces IDLE. If dn_download is still high, the next cycle enters LOAD and the transfer continues without its earlier bytes, so it ends in ERR unless the remaining bytes happen to reach the exact count.
- The core reset OR-ing with status/buttons stays in the top level. This block only contributes core_reset.

Decomposition:
- Package phoenix_rom_pkg:
  - state enum (IDLE, LOAD, DRAIN, HOLD, RUN, ERR);
  - region base/limit constants;
  - region enum;
  - EXPECTED_BYTES default.
- One natural sub-module: phoenix_rom_region_decode, combinational addr -> {in_map, sel, pal, rel_addr}. The FSM, buffer and counters live in phoenix_rom_loader.

Test Plan:
- Full load, 25088 sequential bytes, one dn_wr every 4 cycles, mem_wr_ready = 1 -> 25088 transfers. sel 001 for 16384 bytes, 010 for 4096, 100/pal=0 for 4096, 100/pal=1 for 512. core_reset falls exactly RESET_HOLD cycles after the buffer drains; load_ok = 1; load_err = 0.
- Short image, 25087 bytes -> ERR; load_err = 1, core_reset stays 1, byte_count = 25087.
- Backpressure: mem_wr_ready = 0 for 3 cycles, then writes on 2 consecutive cycles -> first byte held stable, second dropped, load_err = 1. Then ready = 0, write, ready = 1 on the same cycle as the next write -> no drop.
- Out-of-map: bytes at 0x6200-0x7FFF interleaved with a full valid image -> no mem_wr for them, byte_count = 25088, load_ok = 1.
- Reload from RUN: assert dn_download -> core_reset = 1 and load_ok = 0 next cycle, byte_count cleared. A valid second image returns to RUN.
- reset pulse at byte 1000 with dn_download held -> outputs at reset values, then LOAD resumes; 24088 remaining bytes -> ERR.
